// File: rtl/seg7_scan_display.sv
// ---------------------------------------------------------------------------
// seg7_scan_display
//   Time-multiplexed hex display driver for NUM_DIGITS common-anode digits.
//   A result word is captured through a load strobe into a shadow register.
//   It is committed to the display register only at a frame boundary, so a
//   frame never mixes old and new digits. page_sel picks which group of
//   NUM_DIGITS nibbles is shown.
//
//   Optional feature: define SEG7_LEADING_ZERO_BLANK_EN to blank leading
//   zero digits of the selected page. Digit 0 always stays lit.
//
// Ports
//   clock      in   system clock
//   reset      in   synchronous, active-high reset
//   data_in    in   [DATA_W-1:0]     word to display
//   load       in   one-cycle strobe that captures data_in
//   page_sel   in   [PAGE_W-1:0]     page to show (out-of-range -> page 0)
//   dp_in      in   [NUM_DIGITS-1:0] decimal point enable per digit
//   blank_in   in   [NUM_DIGITS-1:0] force digit dark
//   an         out  [NUM_DIGITS-1:0] anode enables, active-low, registered
//   seg        out  [7:0]            {a,b,c,d,e,f,g,dp}, active-low, registered
//   frame_tick out  one-cycle pulse in the frame-boundary cycle
//   pending    out  a loaded word is waiting for the next frame boundary
// ---------------------------------------------------------------------------
module seg7_scan_display #(
  parameter  int NUM_DIGITS = 4,
  parameter  int DATA_W     = 32,
  parameter  int DIV_COUNT  = 260000,
  parameter  int CNT_W      = 18,
  localparam int PAGES      = DATA_W / (4 * NUM_DIGITS),
  localparam int PAGE_W     = (PAGES > 1) ? $clog2(PAGES) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     data_in,
  input  logic                  load,
  input  logic [PAGE_W-1:0]     page_sel,
  input  logic [NUM_DIGITS-1:0] dp_in,
  input  logic [NUM_DIGITS-1:0] blank_in,
  output logic [NUM_DIGITS-1:0] an,
  output logic [7:0]            seg,
  output logic                  frame_tick,
  output logic                  pending
);

  localparam int IDX_W     = $clog2(NUM_DIGITS);
  localparam int NIBS      = DATA_W / 4;
  localparam int NIB_IDX_W = $clog2(NIBS);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_COUNT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  // Active-low glyph on segments a..g.
  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    logic [6:0] g;
    g = 7'b1111111;
    case (v)
      4'h0: g = 7'b0000001;
      4'h1: g = 7'b1001111;
      4'h2: g = 7'b0010010;
      4'h3: g = 7'b0000110;
      4'h4: g = 7'b1001100;
      4'h5: g = 7'b0100100;
      4'h6: g = 7'b0100000;
      4'h7: g = 7'b0001111;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0000100;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b1100000;
      4'hC: g = 7'b0110001;
      4'hD: g = 7'b1000010;
      4'hE: g = 7'b0110000;
      4'hF: g = 7'b0111000;
      default: g = 7'b1111111;
    endcase
    return g;
  endfunction

  // State registers
  logic [CNT_W-1:0]      cnt_q,     cnt_d;
  logic [IDX_W-1:0]      idx_q,     idx_d;
  logic [DATA_W-1:0]     shadow_q,  shadow_d;
  logic [DATA_W-1:0]     disp_q,    disp_d;
  logic [PAGE_W-1:0]     page_q,    page_d;
  logic [NUM_DIGITS-1:0] dp_q,      dp_d;
  logic [NUM_DIGITS-1:0] blank_q,   blank_d;
  logic                  pending_q, pending_d;
  logic [NUM_DIGITS-1:0] an_q,      an_d;
  logic [7:0]            seg_q,     seg_d;

  logic                  tick;
  logic                  boundary;
  logic [PAGE_W-1:0]     page_eff;
  logic [NIB_IDX_W-1:0]  nib_idx;
  logic [3:0]            cur_nib;
  logic [NUM_DIGITS-1:0] blank_eff;

  assign tick     = (cnt_q == CNT_LAST);
  assign boundary = tick && (idx_q == IDX_LAST);

  // An out-of-range page request falls back to page 0.
  assign page_eff = ({1'b0, page_sel} >= (PAGE_W + 1)'(PAGES)) ? '0 : page_sel;

  // Scan timing, load handshake and frame-boundary commit.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned and no latch is inferred.
    cnt_d     = tick ? '0 : cnt_q + 1'b1;
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    disp_d    = disp_q;
    page_d    = page_q;
    dp_d      = dp_q;
    blank_d   = blank_q;
    pending_d = pending_q;

    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    if (boundary) begin
      // A load landing on the boundary bypasses the shadow wait.
      disp_d    = load ? data_in : shadow_q;
      shadow_d  = load ? data_in : shadow_q;
      page_d    = page_eff;
      dp_d      = dp_in;
      blank_d   = blank_in;
      pending_d = 1'b0;
    end else if (load) begin
      shadow_d  = data_in;
      pending_d = 1'b1;
    end
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // Leading-zero mask computed from the word and page being committed, so it
  // stays constant for the whole frame just like the displayed data.
  logic [NUM_DIGITS-1:0] lz_q, lz_d;
  logic [NIB_IDX_W-1:0]  lz_base;
  logic [DATA_W-1:0]     lz_word;
  logic                  lz_seen_nz;

  always_comb begin
    lz_d       = lz_q;
    lz_base    = NIB_IDX_W'(page_d) * NIB_IDX_W'(NUM_DIGITS);
    lz_word    = disp_d >> {lz_base, 2'b00};
    lz_seen_nz = 1'b0;
    if (boundary) begin
      lz_d = '0;
      // Scan from the top digit down; a digit is blank until a non-zero
      // nibble is found at or above it. Digit 0 is never blanked.
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
        lz_seen_nz = lz_seen_nz | (4'(lz_word >> (4 * k)) != 4'h0);
        lz_d[k]    = ~lz_seen_nz;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) lz_q <= '0;
    else       lz_q <= lz_d;
  end

  assign blank_eff = blank_q | lz_q;
`else
  assign blank_eff = blank_q;
`endif

  // Output decode, one cycle behind the digit index.
  always_comb begin
    nib_idx = NIB_IDX_W'(page_q) * NIB_IDX_W'(NUM_DIGITS) + NIB_IDX_W'(idx_q);
    cur_nib = 4'(disp_q >> {nib_idx, 2'b00});
    an_d    = ~(NUM_DIGITS'(1) << idx_q);
    if (blank_eff[idx_q]) begin
      seg_d = 8'hFF;
    end else begin
      seg_d = {hex_glyph(cur_nib), ~dp_q[idx_q]};
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      // NOTE: all registers, including the data-holding shadow/display words, are reset so a pending word is discarded.
      cnt_q     <= '0;
      idx_q     <= '0;
      shadow_q  <= '0;
      disp_q    <= '0;
      page_q    <= '0;
      dp_q      <= '0;
      blank_q   <= '0;
      pending_q <= 1'b0;
      an_q      <= '1;
      seg_q     <= 8'hFF;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      disp_q    <= disp_d;
      page_q    <= page_d;
      dp_q      <= dp_d;
      blank_q   <= blank_d;
      pending_q <= pending_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign pending    = pending_q;
  assign frame_tick = boundary;

endmodule

// File: tb/tb_seg7_scan_display.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_display
//   Directed bench for seg7_scan_display with NUM_DIGITS=4, DATA_W=32,
//   DIV_COUNT=4 (16-cycle frames). Expected glyph bytes are hand-computed.
//   Leading-zero expectations follow SEG7_LEADING_ZERO_BLANK_EN when defined.
// ---------------------------------------------------------------------------
module tb_seg7_scan_display;

  logic        clock;
  logic        reset;
  logic [31:0] data_in;
  logic        load;
  logic [0:0]  page_sel;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic        frame_tick;
  logic        pending;

  int checks = 0;
  int errors = 0;
  int n;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  localparam logic [7:0] LZ_SEG = 8'hFF;
`else
  localparam logic [7:0] LZ_SEG = 8'h03;
`endif

  seg7_scan_display #(
    .NUM_DIGITS(4),
    .DATA_W    (32),
    .DIV_COUNT (4),
    .CNT_W     (3)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .data_in   (data_in),
    .load      (load),
    .page_sel  (page_sel),
    .dp_in     (dp_in),
    .blank_in  (blank_in),
    .an        (an),
    .seg       (seg),
    .frame_tick(frame_tick),
    .pending   (pending)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample and drive 1 time unit after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Step until frame_tick is seen (bounded); returns the number of steps.
  task automatic wait_frame_tick(output int cnt);
    cnt = 0;
    while (!frame_tick && cnt < 64) begin
      step();
      cnt++;
    end
    check("frame_tick_seen", frame_tick, 1'b1);
  endtask

  // Called in a frame-boundary cycle: checks each digit of the new frame.
  task automatic check_frame(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] e [4];
    logic [3:0] exp_an;
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    step();
    load = 1'b0;
    check({tag, "_pend"}, pending, 1'b0);
    step();
    for (int k = 0; k < 4; k++) begin
      if (k > 0) repeat (4) step();
      exp_an = ~(4'b0001 << k);
      check($sformatf("%s_an%0d", tag, k), an, exp_an);
      check($sformatf("%s_seg%0d", tag, k), seg, e[k]);
    end
  endtask

  initial begin
    logic [3:0] exp_an;
    reset    = 1'b1;
    data_in  = '0;
    load     = 1'b0;
    page_sel = '0;
    dp_in    = '0;
    blank_in = '0;

    // Reset held for 3 cycles.
    repeat (3) step();
    check("rst_an", an, 4'b1111);
    check("rst_seg", seg, 8'hFF);
    check("rst_pending", pending, 1'b0);
    check("rst_frame_tick", frame_tick, 1'b0);

    // Scan order after release: every digit shows '0' for 4 cycles.
    reset = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      if (k > 0) repeat (4) step();
      exp_an = ~(4'b0001 << k);
      check($sformatf("scan_an%0d", k), an, exp_an);
      check($sformatf("scan_seg%0d", k), seg, 8'h03);
      check($sformatf("scan_ft%0d", k), frame_tick, 1'b0);
    end
    repeat (4) step();

    // Mid-frame load: pending until boundary, current frame unchanged.
    data_in = 32'h1234_5678;
    load    = 1'b1;
    step();
    load = 1'b0;
    check("load_pending", pending, 1'b1);
    check("load_old_seg", seg, 8'h03);
    check("load_old_an", an, 4'b1110);
    wait_frame_tick(n);
    check("first_boundary_delay", n, 13);
    check("pending_at_boundary", pending, 1'b1);
    check_frame("p0", 8'h01, 8'h1F, 8'h41, 8'h49);

    // Page 1 of the same word.
    page_sel = 1'b1;
    wait_frame_tick(n);
    check_frame("p1", 8'h99, 8'h0D, 8'h25, 8'h9F);
    page_sel = 1'b0;

    // Two loads in one frame: last value wins.
    wait_frame_tick(n);
    repeat (4) step();
    data_in = 32'hAAAA_AAAA;
    load    = 1'b1;
    step();
    data_in = 32'h0000_000F;
    step();
    load = 1'b0;
    check("dbl_pending", pending, 1'b1);
    wait_frame_tick(n);
    check("frame_period", n, 10);
    check_frame("dbl", 8'h71, 8'h03, 8'h03, 8'h03);

    // Load coincident with the boundary goes straight to the display.
    wait_frame_tick(n);
    data_in = 32'hFFFF_FFFF;
    load    = 1'b1;
    check_frame("coinc", 8'h71, 8'h71, 8'h71, 8'h71);

    // Decimal point on digit 1.
    dp_in = 4'b0010;
    wait_frame_tick(n);
    check_frame("dp", 8'h71, 8'h70, 8'h71, 8'h71);
    dp_in = 4'b0000;

    // Leading zeros (blanked only with the optional feature).
    data_in = 32'h0000_0030;
    load    = 1'b1;
    step();
    load = 1'b0;
    check("lz_pending", pending, 1'b1);
    wait_frame_tick(n);
    check_frame("lz", 8'h03, 8'h0D, LZ_SEG, LZ_SEG);

    // blank_in darkens digit 2 and suppresses its dp.
    blank_in = 4'b0100;
    dp_in    = 4'b0100;
    wait_frame_tick(n);
    check_frame("blank", 8'h03, 8'h0D, 8'hFF, LZ_SEG);
    blank_in = 4'b0000;
    dp_in    = 4'b0000;

    // Reset mid-frame drops the pending word.
    data_in = 32'h0000_0009;
    load    = 1'b1;
    step();
    load = 1'b0;
    check("pre_rst_pending", pending, 1'b1);
    reset = 1'b1;
    step();
    check("mid_rst_an", an, 4'b1111);
    check("mid_rst_seg", seg, 8'hFF);
    check("mid_rst_pending", pending, 1'b0);
    check("mid_rst_frame_tick", frame_tick, 1'b0);
    reset = 1'b0;
    step();
    check("post_rst_an", an, 4'b1110);
    check("post_rst_seg", seg, 8'h03);
    wait_frame_tick(n);
    check("post_rst_boundary_delay", n, 14);
    check_frame("post_rst", 8'h03, 8'h03, 8'h03, 8'h03);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish, required finish");
    $fatal(1, "timeout");
  end

endmodule
